dffram_arbiter: RTL and testbench

Two-port arbiter that time-shares the single-port management DFFRAM (256 x 32, synchronous read) between the CPU memory port and the housekeeping read-only SRAM port. It sits between the management core's DFFRAM interface and the DFFRAM macro, alongside the housekeeping SPI's read-back path. The CPU has priority. A pending housekeeping read is forced through after a bounded wait.

---
 rtl/dffram_arbiter_if.sv | 38 +++
 rtl/dffram_arbiter.sv | 130 +++++++++++++
 tb/tb_dffram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dffram_arbiter_if.sv
// rtl/dffram_arbiter_if.sv - CPU, housekeeping and DFFRAM signal bundle for dffram_arbiter.
// slave is the arbiter's view; master is the requester/RAM side.
interface dffram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          hk_req;
    logic [AW-1:0] hk_addr;
    logic          hk_busy;
    logic          hk_rvalid;
    logic [DW-1:0] hk_rdata;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, hk_req, hk_addr, ram_do,
        output cpu_gnt, cpu_rvalid, cpu_rdata, hk_busy, hk_rvalid, hk_rdata,
               ram_en, ram_we, ram_a, ram_di
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, hk_req, hk_addr, ram_do,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, hk_busy, hk_rvalid, hk_rdata,
               ram_en, ram_we, ram_a, ram_di
    );
endinterface

// File: rtl/dffram_arbiter.sv
// rtl/dffram_arbiter.sv - CPU-priority arbiter sharing one DFFRAM with the housekeeping read port.
// Define DFFRAM_ARB_STARVE_EN to force a waiting housekeeping read after MAX_WAIT CPU cycles.
module dffram_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic               core_clk,
    input  logic               core_rst,
    dffram_arbiter_if.slave    bus
);
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        HK_IDLE = 2'd0,
        HK_PEND = 2'd1,
        HK_READ = 2'd2
    } hk_state_t;

    hk_state_t     r_state;
    hk_state_t     w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_hk_rdata;
    logic          r_hk_rvalid;
    logic          r_cpu_rvalid;

    logic          w_hk_slot;
    logic          w_forced;
    logic          w_cpu_gnt;
    logic          w_ram_en;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_ram_a;
    logic [DW-1:0] w_ram_di;

`ifdef DFFRAM_ARB_STARVE_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    logic [3:0] r_wait;
    logic [3:0] w_wait_nxt;

    // Counts CPU-held cycles while pending; saturates so the force stays asserted.
    always_comb begin
        w_wait_nxt = r_wait;
        if (r_state == HK_IDLE && bus.hk_req) begin
            w_wait_nxt = 4'd0;
        end else if (r_state == HK_PEND && !w_hk_slot && r_wait != WAIT_LIMIT) begin
            w_wait_nxt = r_wait + 4'd1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_wait <= 4'd0;
        end else begin
            r_wait <= w_wait_nxt;
        end
    end

    assign w_forced = (r_wait == WAIT_LIMIT);
`else
    assign w_forced = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hk_slot   = 1'b0;
        case (r_state)
            HK_IDLE: if (bus.hk_req) w_state_nxt = HK_PEND;
            HK_PEND: begin
                if (!bus.cpu_req || w_forced) begin
                    w_hk_slot   = 1'b1;
                    w_state_nxt = HK_READ;
                end
            end
            HK_READ: w_state_nxt = HK_IDLE;
            default: w_state_nxt = HK_IDLE;
        endcase
    end

    assign w_cpu_gnt = bus.cpu_req & ~w_hk_slot;

    always_comb begin
        w_ram_en = 1'b0;
        w_ram_we = 4'd0;
        w_ram_a  = '0;
        w_ram_di = '0;
        if (w_hk_slot) begin
            w_ram_en = 1'b1;
            w_ram_a  = r_addr;
        end else if (w_cpu_gnt) begin
            w_ram_en = 1'b1;
            w_ram_we = bus.cpu_we;
            w_ram_a  = bus.cpu_addr;
            w_ram_di = bus.cpu_wdata;
        end
    end

    // A CPU access granted during HK_READ only changes ram_do at the same edge that captures it.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state      <= HK_IDLE;
            r_addr       <= '0;
            r_hk_rdata   <= '0;
            r_hk_rvalid  <= 1'b0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hk_rvalid  <= (r_state == HK_READ);
            r_cpu_rvalid <= w_cpu_gnt && (bus.cpu_we == 4'd0);
            if (r_state == HK_IDLE && bus.hk_req) begin
                r_addr <= bus.hk_addr;
            end
            if (r_state == HK_READ) begin
                r_hk_rdata <= bus.ram_do;
            end
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.cpu_rdata  = r_cpu_rvalid ? bus.ram_do : '0;
    assign bus.hk_busy    = (r_state != HK_IDLE);
    assign bus.hk_rvalid  = r_hk_rvalid;
    assign bus.hk_rdata   = r_hk_rdata;
    assign bus.ram_en     = w_ram_en;
    assign bus.ram_we     = w_ram_we;
    assign bus.ram_a      = w_ram_a;
    assign bus.ram_di     = w_ram_di;
endmodule

// File: tb/tb_dffram_arbiter.sv
// tb/tb_dffram_arbiter.sv - scoreboard bench for dffram_arbiter with a behavioural 256x32 DFFRAM.
module tb_dffram_arbiter;
    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    dffram_arbiter_if #(.AW(8), .DW(32)) bus();

    dffram_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .bus      (bus)
    );

    logic [31:0] mem [0:255];

    always @(posedge core_clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we == 4'd0) begin
                bus.ram_do <= mem[bus.ram_a];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_we[b]) mem[bus.ram_a][8*b +: 8] <= bus.ram_di[8*b +: 8];
                end
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] hk_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge core_clk) begin
        if (bus.cpu_rvalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                n_total++;
                $display("FAIL cpu_rvalid_unexpected: got rvalid with data %h, expected none", bus.cpu_rdata);
            end else begin
                check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
            end
        end
        if (bus.hk_rvalid === 1'b1) begin
            if (hk_q.size() == 0) begin
                n_total++;
                $display("FAIL hk_rvalid_unexpected: got rvalid with data %h, expected none", bus.hk_rdata);
            end else begin
                check("hk_rdata", bus.hk_rdata, hk_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge core_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge core_clk);
    endtask

    task automatic cpu_drive(input logic req, input logic [3:0] we, input logic [7:0] a, input logic [31:0] d);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic hk_drive(input logic req, input logic [7:0] a);
        bus.hk_req  = req;
        bus.hk_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.ram_do = 32'h0;
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);
        hk_drive(1'b0, 8'h00);

        // Reset and idle
        repeat (3) next_cycle();
        core_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            mid();
            check("idle_ram_en", {31'd0, bus.ram_en}, 32'd0);
            check("idle_flags", {26'd0, bus.cpu_gnt, bus.cpu_rvalid, bus.hk_busy, bus.hk_rvalid, bus.ram_we}, 32'd0);
            if (c == 0) begin
                check("idle_ram_a", {24'd0, bus.ram_a}, 32'd0);
                check("idle_ram_di", bus.ram_di, 32'd0);
                check("idle_hk_rdata", bus.hk_rdata, 32'd0);
                check("idle_cpu_rdata", bus.cpu_rdata, 32'd0);
            end
            next_cycle();
        end

        // CPU write then read
        cpu_drive(1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        mid();
        check("cpu_wr_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        check("cpu_wr_ram_we", {28'd0, bus.ram_we}, 32'hF);
        check("cpu_wr_ram_di", bus.ram_di, 32'hDEADBEEF);
        next_cycle();
        cpu_drive(1'b1, 4'h0, 8'h10, 32'h0);
        cpu_q.push_back(32'hDEADBEEF);
        mid();
        check("cpu_rd_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        check("cpu_rd_ram_a", {24'd0, bus.ram_a}, 32'h10);
        next_cycle();
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);
        mid();
        check("cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
        next_cycle();

        cpu_drive(1'b1, 4'hF, 8'h20, 32'h12345678);
        next_cycle();
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);

        // Housekeeping only, back-to-back and a dropped request
        hk_drive(1'b1, 8'h20);
        hk_q.push_back(32'h12345678);
        mid();
        check("hk_c0_busy", {31'd0, bus.hk_busy}, 32'd0);
        next_cycle();
        hk_drive(1'b0, 8'h00);
        mid();
        check("hk_c1_busy", {31'd0, bus.hk_busy}, 32'd1);
        check("hk_c1_ram_en", {31'd0, bus.ram_en}, 32'd1);
        check("hk_c1_ram_a", {24'd0, bus.ram_a}, 32'h20);
        check("hk_c1_ram_we", {28'd0, bus.ram_we}, 32'd0);
        next_cycle();
        mid();
        check("hk_c2_busy", {31'd0, bus.hk_busy}, 32'd1);
        check("hk_c2_rvalid", {31'd0, bus.hk_rvalid}, 32'd0);
        next_cycle();
        hk_drive(1'b1, 8'h10);
        hk_q.push_back(32'hDEADBEEF);
        mid();
        check("hk_c3_rvalid", {31'd0, bus.hk_rvalid}, 32'd1);
        check("hk_c3_busy", {31'd0, bus.hk_busy}, 32'd0);
        next_cycle();
        hk_drive(1'b1, 8'h20);
        mid();
        check("hk_drop_ram_a", {24'd0, bus.ram_a}, 32'h10);
        next_cycle();
        hk_drive(1'b0, 8'h00);
        next_cycle();
        mid();
        check("hk_b2b_rvalid", {31'd0, bus.hk_rvalid}, 32'd1);
        next_cycle();

        // hk_req and cpu_req together in HK_IDLE
        cpu_drive(1'b1, 4'h0, 8'h20, 32'h0);
        hk_drive(1'b1, 8'h10);
        cpu_q.push_back(32'h12345678);
        hk_q.push_back(32'hDEADBEEF);
        mid();
        check("same_cpu_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        check("same_ram_a", {24'd0, bus.ram_a}, 32'h20);
        next_cycle();
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);
        hk_drive(1'b0, 8'h00);
        mid();
        check("same_hk_ram_a", {24'd0, bus.ram_a}, 32'h10);
        next_cycle();
        next_cycle();
        mid();
        check("same_hk_rvalid", {31'd0, bus.hk_rvalid}, 32'd1);
        next_cycle();

        // Contention with continuous CPU reads
        cpu_drive(1'b1, 4'h0, 8'h10, 32'h0);
        hk_drive(1'b1, 8'h20);
        hk_q.push_back(32'h12345678);
        cpu_q.push_back(32'hDEADBEEF);
        mid();
        check("cont_c0_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
        next_cycle();
        hk_drive(1'b0, 8'h00);
`ifdef DFFRAM_ARB_STARVE_EN
        for (int c = 1; c <= 8; c++) begin
            logic exp_gnt;
            exp_gnt = (c != 5);
            if (exp_gnt) cpu_q.push_back(32'hDEADBEEF);
            mid();
            check("cont_gnt", {31'd0, bus.cpu_gnt}, {31'd0, exp_gnt});
            if (c == 5) check("cont_forced_ram_a", {24'd0, bus.ram_a}, 32'h20);
            if (c == 7) check("cont_hk_rvalid", {31'd0, bus.hk_rvalid}, 32'd1);
            next_cycle();
        end
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);
`else
        for (int c = 1; c <= 50; c++) begin
            cpu_q.push_back(32'hDEADBEEF);
            mid();
            check("strict_gnt", {31'd0, bus.cpu_gnt}, 32'd1);
            check("strict_busy", {31'd0, bus.hk_busy}, 32'd1);
            next_cycle();
        end
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);
        mid();
        check("strict_slot_ram_a", {24'd0, bus.ram_a}, 32'h20);
        check("strict_slot_ram_en", {31'd0, bus.ram_en}, 32'd1);
        next_cycle();
        next_cycle();
        mid();
        check("strict_hk_rvalid", {31'd0, bus.hk_rvalid}, 32'd1);
        next_cycle();
`endif
        repeat (3) next_cycle();

        // Reset asserted in the HK_READ cycle, with a CPU read granted alongside
        hk_drive(1'b1, 8'h20);
        next_cycle();
        hk_drive(1'b0, 8'h00);
        next_cycle();
        core_rst = 1'b1;
        cpu_drive(1'b1, 4'h0, 8'h10, 32'h0);
        mid();
        check("rst_in_read_busy", {31'd0, bus.hk_busy}, 32'd1);
        next_cycle();
        core_rst = 1'b0;
        cpu_drive(1'b0, 4'h0, 8'h00, 32'h0);
        mid();
        check("rst_hk_rvalid", {31'd0, bus.hk_rvalid}, 32'd0);
        check("rst_hk_rdata", bus.hk_rdata, 32'd0);
        check("rst_hk_busy", {31'd0, bus.hk_busy}, 32'd0);
        check("rst_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
        next_cycle();
        repeat (4) next_cycle();

        check("cpu_q_drained", cpu_q.size(), 32'd0);
        check("hk_q_drained", hk_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
